// File: rtl/sudc_monitor_pkg.sv
// rtl/sudc_monitor_pkg.sv - shared state and delta-class types for the up/down counter monitor
package sudc_mon_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_SYNC,
    ST_UP,
    ST_DOWN
  } mon_state_t;

  typedef enum logic [1:0] {
    DC_ZERO,
    DC_INC,
    DC_DEC,
    DC_BAD
  } delta_cls_t;

endpackage

// File: rtl/sudc_monitor_if.sv
// rtl/sudc_monitor_if.sv - count sample stream in, direction/error/position status out
interface sudc_monitor_if #(
  parameter int WIDTH = 4,
  parameter int POS_W = 16,
  parameter int ERR_W = 8
);
  logic             sample_en;
  logic [WIDTH-1:0] q_in;
  logic             dir;
  logic             dir_valid;
  logic             dir_chg;
  logic             step_err;
  logic [ERR_W-1:0] err_cnt;
  logic             stall;
  logic [POS_W-1:0] pos;

  // Counter side: presents samples, observes status
  modport master (
    output sample_en, q_in,
    input  dir, dir_valid, dir_chg, step_err, err_cnt, stall, pos
  );

  // Monitor side: consumes samples, drives status
  modport slave (
    input  sample_en, q_in,
    output dir, dir_valid, dir_chg, step_err, err_cnt, stall, pos
  );
endinterface

// File: rtl/sudc_monitor_delta_cls.sv
// rtl/sudc_monitor_delta_cls.sv - combinational modulo-2^WIDTH delta and step classifier
import sudc_mon_pkg::*;

module sudc_delta_cls #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] prev,
  output delta_cls_t       cls
);
  logic [WIDTH-1:0] delta;

  // Subtraction wraps naturally, so 15->0 is +1 and 0->15 is all ones
  always_comb begin
    delta = q_in - prev;
    if (delta == '0)
      cls = DC_ZERO;
    else if (delta == WIDTH'(1))
      cls = DC_INC;
    else if (delta == {WIDTH{1'b1}})
      cls = DC_DEC;
    else
      cls = DC_BAD;
  end
endmodule

// File: rtl/sudc_monitor.sv
// rtl/sudc_monitor.sv - direction/reversal/error/stall checker for a counter bus; SUDC_MON_POS_EN builds the position accumulator
import sudc_mon_pkg::*;

module sudc_monitor #(
  parameter int WIDTH     = 4,
  parameter int STALL_MAX = 3,
  parameter int POS_W     = 16,
  parameter int ERR_W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  sudc_monitor_if.slave bus
);
  localparam int SC_W = $clog2(STALL_MAX + 1);

  mon_state_t       state;
  delta_cls_t       cls;
  logic [WIDTH-1:0] prev;
  logic             dir_r;
  logic             dir_valid_r;
  logic             dir_chg_r;
  logic             step_err_r;
  logic [ERR_W-1:0] err_cnt_r;
  logic [SC_W-1:0]  stall_cnt;
  logic             classify;

  sudc_delta_cls #(.WIDTH(WIDTH)) u_cls (
    .q_in (bus.q_in),
    .prev (prev),
    .cls  (cls)
  );

  // The very first sample after reset only seeds prev; everything else is classified
  assign classify = bus.sample_en && (state != ST_INIT);

  // Direction FSM with registered direction, lock and pulse outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_INIT;
      prev        <= '0;
      dir_r       <= 1'b0;
      dir_valid_r <= 1'b0;
      dir_chg_r   <= 1'b0;
      step_err_r  <= 1'b0;
    end else begin
      dir_chg_r  <= 1'b0;
      step_err_r <= 1'b0;
      if (bus.sample_en) begin
        prev <= bus.q_in;
        case (state)
          ST_INIT: state <= ST_SYNC;
          ST_SYNC: begin
            case (cls)
              DC_INC: begin
                state <= ST_UP;  dir_r <= 1'b1; dir_valid_r <= 1'b1;
              end
              DC_DEC: begin
                state <= ST_DOWN; dir_r <= 1'b0; dir_valid_r <= 1'b1;
              end
              DC_BAD:  step_err_r <= 1'b1;
              default: ;
            endcase
          end
          ST_UP: begin
            case (cls)
              DC_DEC: begin
                state <= ST_DOWN; dir_r <= 1'b0; dir_chg_r <= 1'b1;
              end
              DC_BAD: begin
                state <= ST_SYNC; dir_valid_r <= 1'b0; step_err_r <= 1'b1;
              end
              default: ;
            endcase
          end
          ST_DOWN: begin
            case (cls)
              DC_INC: begin
                state <= ST_UP; dir_r <= 1'b1; dir_chg_r <= 1'b1;
              end
              DC_BAD: begin
                state <= ST_SYNC; dir_valid_r <= 1'b0; step_err_r <= 1'b1;
              end
              default: ;
            endcase
          end
          default: state <= ST_INIT;
        endcase
      end
    end
  end

  // Consecutive zero-delta counter, saturating at STALL_MAX
  always_ff @(posedge clk) begin
    if (!rst)
      stall_cnt <= '0;
    else if (classify) begin
      if (cls == DC_ZERO) begin
        if (stall_cnt != SC_W'(STALL_MAX))
          stall_cnt <= stall_cnt + 1'b1;
      end else
        stall_cnt <= '0;
    end
  end

  // Saturating count of illegal steps, one per step_err pulse
  always_ff @(posedge clk) begin
    if (!rst)
      err_cnt_r <= '0;
    else if (classify && (cls == DC_BAD) && (err_cnt_r != {ERR_W{1'b1}}))
      err_cnt_r <= err_cnt_r + 1'b1;
  end

`ifdef SUDC_MON_POS_EN
  localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
  logic [POS_W-1:0] pos_r;

  // Signed net-step accumulator that clamps rather than wraps
  always_ff @(posedge clk) begin
    if (!rst)
      pos_r <= '0;
    else if (classify) begin
      if (cls == DC_INC && pos_r != POS_MAX)
        pos_r <= pos_r + 1'b1;
      else if (cls == DC_DEC && pos_r != POS_MIN)
        pos_r <= pos_r - 1'b1;
    end
  end

  assign bus.pos = pos_r;
`else
  assign bus.pos = '0;
`endif

  assign bus.dir       = dir_r;
  assign bus.dir_valid = dir_valid_r;
  assign bus.dir_chg   = dir_chg_r;
  assign bus.step_err  = step_err_r;
  assign bus.err_cnt   = err_cnt_r;
  assign bus.stall     = (stall_cnt == SC_W'(STALL_MAX));
endmodule
